// File: rtl/start_ack_ctrl.sv
// Start/ack program sequencer: selects a program base, loads the PC, runs the core until Halt, then acks.
// Latency: Start->LOAD and Halt->DONE take one cycle; outputs are decoded from registered state only.
// Handshake: level Start, no backpressure; optional watchdog under START_ACK_CTRL_WATCHDOG_EN forces DONE with Timeout.
module start_ack_ctrl #(
    parameter int          PC_W    = 10,
    parameter int          P1_BASE = 0,
    parameter int          P2_BASE = 256,
    parameter int          P3_BASE = 512,
    parameter logic [15:0] MAX_RUN = 16'hFFFF
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic            Start,
    input  logic            Halt,
    output logic            PcLoad,
    output logic [PC_W-1:0] PcStartAddr,
    output logic            CoreEn,
    output logic [1:0]      ProgSel,
    output logic            Ack,
    output logic            Timeout,
    output logic [15:0]     CycleCount
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [PC_W-1:0] P1_ADDR = PC_W'(P1_BASE);
    localparam logic [PC_W-1:0] P2_ADDR = PC_W'(P2_BASE);
    localparam logic [PC_W-1:0] P3_ADDR = PC_W'(P3_BASE);

    state_t      state;
    state_t      state_nxt;
    logic [1:0]  sel_nxt;
    logic [15:0] cnt_nxt;
    logic [15:0] cnt_inc;
    logic        tmo_nxt;
    logic        wd_hit;

    assign cnt_inc = (CycleCount == 16'hFFFF) ? CycleCount : CycleCount + 16'd1;

`ifdef START_ACK_CTRL_WATCHDOG_EN
    // Fires on the RUN cycle whose count reaches the limit, so DONE shows exactly MAX_RUN.
    assign wd_hit = (cnt_inc >= MAX_RUN);
`else
    assign wd_hit = 1'b0;
`endif

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state      <= IDLE;
            ProgSel    <= 2'd0;
            CycleCount <= 16'd0;
            Timeout    <= 1'b0;
        end else begin
            state      <= state_nxt;
            ProgSel    <= sel_nxt;
            CycleCount <= cnt_nxt;
            Timeout    <= tmo_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        sel_nxt   = ProgSel;
        cnt_nxt   = CycleCount;
        tmo_nxt   = Timeout;
        PcLoad    = 1'b0;
        CoreEn    = 1'b0;
        Ack       = 1'b0;
        case (state)
            IDLE: begin
                if (Start) begin
                    state_nxt = LOAD;
                    cnt_nxt   = 16'd0;
                    tmo_nxt   = 1'b0;
                end
            end
            LOAD: begin
                PcLoad  = 1'b1;
                cnt_nxt = 16'd0;
                tmo_nxt = 1'b0;
                if (!Start) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                CoreEn  = 1'b1;
                cnt_nxt = cnt_inc;
                // Halt takes priority over both Start and the watchdog.
                if (Halt) begin
                    state_nxt = DONE;
                end else if (wd_hit) begin
                    state_nxt = DONE;
                    tmo_nxt   = 1'b1;
                end
            end
            DONE: begin
                Ack = 1'b1;
                if (Start) begin
                    state_nxt = LOAD;
                    sel_nxt   = (ProgSel == 2'd2) ? 2'd0 : ProgSel + 2'd1;
                    cnt_nxt   = 16'd0;
                    tmo_nxt   = 1'b0;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_comb begin
        case (ProgSel)
            2'd1:    PcStartAddr = P2_ADDR;
            2'd2:    PcStartAddr = P3_ADDR;
            default: PcStartAddr = P1_ADDR;
        endcase
    end

endmodule

// File: tb/tb_start_ack_ctrl.sv
// Directed bench for start_ack_ctrl; watchdog checks follow START_ACK_CTRL_WATCHDOG_EN.
module tb_start_ack_ctrl;

    localparam logic [15:0] MAXR = 16'd20;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        Start = 1'b0;
    logic        Halt = 1'b0;
    logic        PcLoad;
    logic [9:0]  PcStartAddr;
    logic        CoreEn;
    logic [1:0]  ProgSel;
    logic        Ack;
    logic        Timeout;
    logic [15:0] CycleCount;

    int vec = 0;
    int errs = 0;

    start_ack_ctrl #(
        .PC_W(10), .P1_BASE(0), .P2_BASE(256), .P3_BASE(512), .MAX_RUN(MAXR)
    ) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Halt(Halt),
        .PcLoad(PcLoad), .PcStartAddr(PcStartAddr), .CoreEn(CoreEn),
        .ProgSel(ProgSel), .Ack(Ack), .Timeout(Timeout), .CycleCount(CycleCount)
    );

    always #5 Clk = ~Clk;

    task automatic tick(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        Reset = 1'b1; Start = 1'b0; Halt = 1'b0;
        tick(2);
        Reset = 1'b0;
    endtask

    task automatic test_reset();
        Reset = 1'b1; Start = 1'b1; Halt = 1'b1;
        tick(2);
        vec++; if (PcLoad !== 1'b0) begin errs++; $display("FAIL rst_pcload got %0b want 0", PcLoad); end
        vec++; if (PcStartAddr !== 10'd0) begin errs++; $display("FAIL rst_addr got %0d want 0", PcStartAddr); end
        vec++; if (CoreEn !== 1'b0) begin errs++; $display("FAIL rst_coreen got %0b want 0", CoreEn); end
        vec++; if (ProgSel !== 2'd0) begin errs++; $display("FAIL rst_progsel got %0d want 0", ProgSel); end
        vec++; if (Ack !== 1'b0) begin errs++; $display("FAIL rst_ack got %0b want 0", Ack); end
        vec++; if (Timeout !== 1'b0) begin errs++; $display("FAIL rst_timeout got %0b want 0", Timeout); end
        vec++; if (CycleCount !== 16'd0) begin errs++; $display("FAIL rst_count got %0d want 0", CycleCount); end
        Reset = 1'b0; Start = 1'b0;
        tick(1);
        vec++; if ({PcLoad, CoreEn, Ack} !== 3'b000) begin errs++; $display("FAIL idle_halt_ignored got %b want 000", {PcLoad, CoreEn, Ack}); end
        Halt = 1'b0;
    endtask

    task automatic test_basic_run();
        do_reset();
        Start = 1'b1; tick(1); Start = 1'b0;
        vec++; if (PcLoad !== 1'b1) begin errs++; $display("FAIL basic_pcload got %0b want 1", PcLoad); end
        vec++; if (PcStartAddr !== 10'd0) begin errs++; $display("FAIL basic_addr got %0d want 0", PcStartAddr); end
        vec++; if (CoreEn !== 1'b0) begin errs++; $display("FAIL basic_load_coreen got %0b want 0", CoreEn); end
        vec++; if (CycleCount !== 16'd0) begin errs++; $display("FAIL basic_load_count got %0d want 0", CycleCount); end
        tick(1);
        vec++; if ({PcLoad, CoreEn} !== 2'b01) begin errs++; $display("FAIL basic_run_entry got %b want 01", {PcLoad, CoreEn}); end
        tick(39);
        vec++; if (CycleCount !== 16'd39) begin errs++; $display("FAIL basic_count39 got %0d want 39", CycleCount); end
        vec++; if (Ack !== 1'b0) begin errs++; $display("FAIL basic_early_ack got %0b want 0", Ack); end
        Halt = 1'b1; tick(1); Halt = 1'b0;
        vec++; if (Ack !== 1'b1) begin errs++; $display("FAIL basic_ack got %0b want 1", Ack); end
        vec++; if (CycleCount !== 16'd40) begin errs++; $display("FAIL basic_count40 got %0d want 40", CycleCount); end
        vec++; if (ProgSel !== 2'd0) begin errs++; $display("FAIL basic_progsel got %0d want 0", ProgSel); end
        vec++; if ({PcLoad, CoreEn} !== 2'b00) begin errs++; $display("FAIL basic_done_ctrl got %b want 00", {PcLoad, CoreEn}); end
        tick(3);
        vec++; if ({Ack, CycleCount} !== {1'b1, 16'd40}) begin errs++; $display("FAIL basic_done_hold got ack=%0b cnt=%0d want ack=1 cnt=40", Ack, CycleCount); end
    endtask

    task automatic test_back_to_back();
        logic [9:0] exp_addr [4] = '{10'd0, 10'd256, 10'd512, 10'd0};
        logic [1:0] exp_sel  [4] = '{2'd0, 2'd1, 2'd2, 2'd0};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            Start = 1'b1; tick(1); Start = 1'b0;
            vec++; if (PcLoad !== 1'b1) begin errs++; $display("FAIL b2b_pcload run%0d got %0b want 1", i, PcLoad); end
            vec++; if (Ack !== 1'b0) begin errs++; $display("FAIL b2b_ack_drop run%0d got %0b want 0", i, Ack); end
            vec++; if (ProgSel !== exp_sel[i]) begin errs++; $display("FAIL b2b_progsel run%0d got %0d want %0d", i, ProgSel, exp_sel[i]); end
            vec++; if (PcStartAddr !== exp_addr[i]) begin errs++; $display("FAIL b2b_addr run%0d got %0d want %0d", i, PcStartAddr, exp_addr[i]); end
            tick(3);
            Halt = 1'b1; tick(1); Halt = 1'b0;
            vec++; if (Ack !== 1'b1) begin errs++; $display("FAIL b2b_ack run%0d got %0b want 1", i, Ack); end
        end
    endtask

    task automatic test_long_start();
        do_reset();
        Start = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            vec++; if ({PcLoad, CoreEn} !== 2'b10) begin errs++; $display("FAIL long_load cyc%0d got %b want 10", i, {PcLoad, CoreEn}); end
        end
        Start = 1'b0; tick(1);
        vec++; if ({PcLoad, CoreEn} !== 2'b01) begin errs++; $display("FAIL long_run got %b want 01", {PcLoad, CoreEn}); end
        Halt = 1'b1; tick(1); Halt = 1'b0;
    endtask

    task automatic test_reset_midrun();
        do_reset();
        Start = 1'b1; tick(1); Start = 1'b0; tick(1);
        Halt = 1'b1; tick(1); Halt = 1'b0;
        Start = 1'b1; tick(1); Start = 1'b0; tick(1);
        tick(9);
        vec++; if ({ProgSel, CycleCount} !== {2'd1, 16'd9}) begin errs++; $display("FAIL mid_pre got sel=%0d cnt=%0d want sel=1 cnt=9", ProgSel, CycleCount); end
        Reset = 1'b1; Start = 1'b1; Halt = 1'b1; tick(1);
        Reset = 1'b0; Start = 1'b0; Halt = 1'b0;
        vec++; if (Ack !== 1'b0) begin errs++; $display("FAIL mid_ack got %0b want 0", Ack); end
        vec++; if (CycleCount !== 16'd0) begin errs++; $display("FAIL mid_count got %0d want 0", CycleCount); end
        vec++; if (ProgSel !== 2'd0) begin errs++; $display("FAIL mid_progsel got %0d want 0", ProgSel); end
        vec++; if ({PcLoad, CoreEn} !== 2'b00) begin errs++; $display("FAIL mid_idle got %b want 00", {PcLoad, CoreEn}); end
        tick(2);
        vec++; if (Ack !== 1'b0) begin errs++; $display("FAIL mid_no_ack got %0b want 0", Ack); end
        Start = 1'b1; tick(1); Start = 1'b0;
        vec++; if ({PcLoad, ProgSel, PcStartAddr} !== {1'b1, 2'd0, 10'd0}) begin errs++; $display("FAIL mid_restart got load=%0b sel=%0d addr=%0d want 1/0/0", PcLoad, ProgSel, PcStartAddr); end
        tick(1); Halt = 1'b1; tick(1); Halt = 1'b0;
    endtask

    task automatic test_start_halt_same();
        do_reset();
        Start = 1'b1; tick(1); Start = 1'b0; tick(1);
        Start = 1'b1; tick(2);
        vec++; if ({CoreEn, CycleCount} !== {1'b1, 16'd2}) begin errs++; $display("FAIL sh_start_ignored got en=%0b cnt=%0d want en=1 cnt=2", CoreEn, CycleCount); end
        Halt = 1'b1; tick(1); Halt = 1'b0;
        vec++; if (Ack !== 1'b1) begin errs++; $display("FAIL sh_ack got %0b want 1", Ack); end
        vec++; if (ProgSel !== 2'd0) begin errs++; $display("FAIL sh_progsel got %0d want 0", ProgSel); end
        vec++; if (CycleCount !== 16'd3) begin errs++; $display("FAIL sh_count got %0d want 3", CycleCount); end
        tick(1); Start = 1'b0;
        vec++; if ({Ack, PcLoad, ProgSel, PcStartAddr} !== {1'b0, 1'b1, 2'd1, 10'd256}) begin errs++; $display("FAIL sh_reload got ack=%0b load=%0b sel=%0d addr=%0d want 0/1/1/256", Ack, PcLoad, ProgSel, PcStartAddr); end
    endtask

    task automatic test_watchdog();
        do_reset();
        Start = 1'b1; tick(1); Start = 1'b0; tick(1);
`ifdef START_ACK_CTRL_WATCHDOG_EN
        tick(19);
        vec++; if ({Ack, CoreEn, CycleCount} !== {1'b0, 1'b1, 16'd19}) begin errs++; $display("FAIL wd_pre got ack=%0b en=%0b cnt=%0d want 0/1/19", Ack, CoreEn, CycleCount); end
        tick(1);
        vec++; if (Ack !== 1'b1) begin errs++; $display("FAIL wd_ack got %0b want 1", Ack); end
        vec++; if (Timeout !== 1'b1) begin errs++; $display("FAIL wd_timeout got %0b want 1", Timeout); end
        vec++; if (CycleCount !== 16'd20) begin errs++; $display("FAIL wd_count got %0d want 20", CycleCount); end
        Start = 1'b1; tick(1); Start = 1'b0;
        vec++; if (Timeout !== 1'b0) begin errs++; $display("FAIL wd_load_clear got %0b want 0", Timeout); end
        tick(1); tick(19);
        Halt = 1'b1; tick(1); Halt = 1'b0;
        vec++; if ({Ack, Timeout, CycleCount} !== {1'b1, 1'b0, 16'd20}) begin errs++; $display("FAIL wd_halt_wins got ack=%0b to=%0b cnt=%0d want 1/0/20", Ack, Timeout, CycleCount); end
`else
        for (int i = 0; i < 100; i++) begin
            tick(1);
            vec++; if (Ack !== 1'b0) begin errs++; $display("FAIL nowd_ack cyc%0d got %0b want 0", i, Ack); end
        end
        vec++; if ({Timeout, CoreEn, CycleCount} !== {1'b0, 1'b1, 16'd100}) begin errs++; $display("FAIL nowd_run got to=%0b en=%0b cnt=%0d want 0/1/100", Timeout, CoreEn, CycleCount); end
        tick(65440);
        vec++; if (CycleCount !== 16'hFFFF) begin errs++; $display("FAIL nowd_saturate got %0h want ffff", CycleCount); end
        Halt = 1'b1; tick(1); Halt = 1'b0;
        vec++; if ({Ack, Timeout, CycleCount} !== {1'b1, 1'b0, 16'hFFFF}) begin errs++; $display("FAIL nowd_halt got ack=%0b to=%0b cnt=%0h want 1/0/ffff", Ack, Timeout, CycleCount); end
`endif
    endtask

    initial begin
        test_reset();
        test_basic_run();
        test_back_to_back();
        test_long_start();
        test_reset_midrun();
        test_start_halt_same();
        test_watchdog();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
